// File: rtl/demux8_buf.sv
// Registered 1-to-8 demultiplexer with per-slot holding registers and consumer acks.
// Optional DEMUX8_OVERWRITE_EN: never stall; writes to full slots set sticky ovf flags.
module demux8_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       s,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] y5,
    output logic [WIDTH-1:0] y6,
    output logic [WIDTH-1:0] y7,
    output logic [7:0]       y_valid,
    input  logic [7:0]       y_ack
`ifdef DEMUX8_OVERWRITE_EN
    ,
    output logic [7:0]       ovf
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t      r_state [8];
    logic [WIDTH-1:0] r_data  [8];
    logic             w_write;
`ifdef DEMUX8_OVERWRITE_EN
    logic [7:0]       r_ovf;
`endif

    // Accept decision: a slot can take a word when empty or being drained this cycle.
    always_comb begin
        in_ready = 1'b0;
        if (rst) begin
            in_ready = 1'b0;
        end else begin
`ifdef DEMUX8_OVERWRITE_EN
            in_ready = 1'b1;
`else
            in_ready = (r_state[s] == EMPTY) | y_ack[s];
`endif
        end
        w_write = in_valid & in_ready;
    end

    // Per-slot EMPTY/FULL state machines, data capture and overwrite flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_state[i] <= EMPTY;
                r_data[i]  <= '0;
            end
`ifdef DEMUX8_OVERWRITE_EN
            r_ovf <= 8'h00;
`endif
        end else begin
            for (int i = 0; i < 8; i++) begin
                // A write to a slot dominates a same-cycle ack on it.
                case (r_state[i])
                    EMPTY: begin
                        if (w_write && (s == 3'(i))) begin
                            r_state[i] <= FULL;
                        end else begin
                            r_state[i] <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (w_write && (s == 3'(i))) begin
                            r_state[i] <= FULL;
                        end else if (y_ack[i]) begin
                            r_state[i] <= EMPTY;
                        end else begin
                            r_state[i] <= FULL;
                        end
                    end
                    default: r_state[i] <= EMPTY;
                endcase
                if (w_write && (s == 3'(i))) begin
                    r_data[i] <= d;
                end
`ifdef DEMUX8_OVERWRITE_EN
                if (w_write && (s == 3'(i)) && (r_state[i] == FULL) && !y_ack[i]) begin
                    r_ovf[i] <= 1'b1;
                end
`endif
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            y_valid[i] = (r_state[i] == FULL);
        end
    end

    assign y0 = r_data[0];
    assign y1 = r_data[1];
    assign y2 = r_data[2];
    assign y3 = r_data[3];
    assign y4 = r_data[4];
    assign y5 = r_data[5];
    assign y6 = r_data[6];
    assign y7 = r_data[7];
`ifdef DEMUX8_OVERWRITE_EN
    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_demux8_buf.sv
// Self-checking bench for demux8_buf: table-driven vectors plus hand-written stall/overwrite sequences.
module tb_demux8_buf;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] d;
    logic [2:0]  s;
    logic [31:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic [7:0]  y_valid;
    logic [7:0]  y_ack;
`ifdef DEMUX8_OVERWRITE_EN
    logic [7:0]  ovf;
`endif
    logic [31:0] y_arr [8];

    int tests_run = 0;
    int tests_failed = 0;

    demux8_buf #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .d(d), .s(s),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
        .y_valid(y_valid), .y_ack(y_ack)
`ifdef DEMUX8_OVERWRITE_EN
        , .ovf(ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        y_arr[0] = y0; y_arr[1] = y1; y_arr[2] = y2; y_arr[3] = y3;
        y_arr[4] = y4; y_arr[5] = y5; y_arr[6] = y6; y_arr[7] = y7;
    end

    typedef struct {
        logic        rst;
        logic        iv;
        logic [2:0]  s;
        logic [31:0] d;
        logic [7:0]  ack;
        logic        exp_rdy;
        logic [7:0]  exp_v;
        logic [2:0]  chk;
        logic [31:0] exp_y;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic iv, input logic [2:0] sel, input logic [31:0] dd,
                       input logic [7:0] ack, input logic rdy, input logic [7:0] v,
                       input logic [2:0] c, input logic [31:0] y);
        vec_t t;
        t.rst = r; t.iv = iv; t.s = sel; t.d = dd; t.ack = ack;
        t.exp_rdy = rdy; t.exp_v = v; t.chk = c; t.exp_y = y;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic iv, input logic [2:0] sel,
                         input logic [31:0] dd, input logic [7:0] ack);
        rst = r; in_valid = iv; s = sel; d = dd; y_ack = ack;
    endtask

    // Drive inputs, check in_ready before the edge, check registered outputs after it.
    task automatic apply(input vec_t v, input int idx);
        drive(v.rst, v.iv, v.s, v.d, v.ack);
        #1;
        check($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, {31'd0, v.exp_rdy});
        @(posedge clk);
        #1;
        check($sformatf("v%0d y_valid", idx), {24'd0, y_valid}, {24'd0, v.exp_v});
        check($sformatf("v%0d y%0d", idx, v.chk), y_arr[v.chk], v.exp_y);
        if (v.rst) begin
            for (int k = 0; k < 8; k++) begin
                check($sformatf("v%0d reset y%0d", idx, k), y_arr[k], 32'h0000_0000);
            end
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'd0, 32'h0, 8'h00);
`ifndef DEMUX8_OVERWRITE_EN
        // Reset held two cycles with a pending offer.
        add(1'b1, 1'b1, 3'd0, 32'h0000_0001, 8'h00, 1'b0, 8'h00, 3'd0, 32'h0);
        add(1'b1, 1'b1, 3'd7, 32'h0000_0002, 8'h00, 1'b0, 8'h00, 3'd7, 32'h0);
        // Fill all eight slots back to back.
        for (int i = 0; i < 8; i++) begin
            add(1'b0, 1'b1, 3'(i), 32'h1000_0000 + 32'(i), 8'h00, 1'b1,
                8'((16'd1 << (i + 1)) - 16'd1), 3'(i), 32'h1000_0000 + 32'(i));
        end
        // Stall on full slot 3, then accept while acked.
        add(1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, 8'h00, 1'b0, 8'hFF, 3'd3, 32'h1000_0003);
        add(1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, 8'h08, 1'b1, 8'hFF, 3'd3, 32'hDEAD_BEEF);
        // Drain slot 5 (no offer), then write 5 while acking 2.
        add(1'b0, 1'b0, 3'd0, 32'h0, 8'h20, 1'b0, 8'hDF, 3'd5, 32'h1000_0005);
        add(1'b0, 1'b1, 3'd5, 32'h5555_5555, 8'h04, 1'b1, 8'hFB, 3'd2, 32'h1000_0002);
        // Ack on empty slot has no effect; multiple acks at once.
        add(1'b0, 1'b0, 3'd2, 32'h0, 8'h04, 1'b1, 8'hFB, 3'd5, 32'h5555_5555);
        add(1'b0, 1'b0, 3'd0, 32'h0, 8'h81, 1'b1, 8'h7A, 3'd0, 32'h1000_0000);
        // Write plus ack on the same (empty) slot: write wins.
        add(1'b0, 1'b1, 3'd0, 32'h0000_000A, 8'h01, 1'b1, 8'h7B, 3'd0, 32'h0000_000A);
        // No in_valid: nothing written regardless of ready.
        add(1'b0, 1'b0, 3'd1, 32'h0000_0BAD, 8'h00, 1'b0, 8'h7B, 3'd1, 32'h1000_0001);
        add(1'b0, 1'b0, 3'd2, 32'h0000_0BAD, 8'h00, 1'b1, 8'h7B, 3'd2, 32'h1000_0002);
        add(1'b0, 1'b1, 3'd2, 32'h0000_2222, 8'h00, 1'b1, 8'h7F, 3'd2, 32'h0000_2222);
        add(1'b0, 1'b1, 3'd7, 32'h0000_7777, 8'h00, 1'b1, 8'hFF, 3'd7, 32'h0000_7777);
        // Mid-stream reset discards everything.
        add(1'b1, 1'b1, 3'd3, 32'h0000_3333, 8'h00, 1'b0, 8'h00, 3'd3, 32'h0);
        add(1'b0, 1'b0, 3'd3, 32'h0, 8'h00, 1'b1, 8'h00, 3'd7, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Repeated stall on slot 4 for several cycles, then release by ack.
        drive(1'b0, 1'b1, 3'd4, 32'h0000_0044, 8'h00);
        @(posedge clk); #1;
        check("seq fill y4", y4, 32'h0000_0044);
        drive(1'b0, 1'b1, 3'd4, 32'h0000_00BB, 8'h00);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("seq stall%0d ready", c), {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            check($sformatf("seq stall%0d y4", c), y4, 32'h0000_0044);
        end
        y_ack = 8'h10;
        #1;
        check("seq release ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("seq release y4", y4, 32'h0000_00BB);
        check("seq release valid", {24'd0, y_valid}, 32'h0000_0010);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 8'h10);
        @(posedge clk); #1;
        check("seq drain valid", {24'd0, y_valid}, 32'h0000_0000);
        check("seq drain y4 kept", y4, 32'h0000_00BB);
`else
        repeat (2) @(posedge clk);
        #1;
        check("ovr reset ovf", {24'd0, ovf}, 32'h0);
        check("ovr reset ready", {31'd0, in_ready}, 32'd0);
        drive(1'b0, 1'b1, 3'd0, 32'h0000_0001, 8'h00);
        @(posedge clk); #1;
        check("ovr first ovf", {24'd0, ovf}, 32'h0);
        drive(1'b0, 1'b1, 3'd0, 32'hCAFE_0001, 8'h00);
        #1;
        check("ovr full ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("ovr y0", y0, 32'hCAFE_0001);
        check("ovr ovf set", {24'd0, ovf}, 32'h1);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 8'h01);
        repeat (2) @(posedge clk);
        #1;
        check("ovr ovf sticky", {24'd0, ovf}, 32'h1);
        check("ovr valid drained", {24'd0, y_valid}, 32'h0);
        drive(1'b0, 1'b1, 3'd1, 32'h0000_0011, 8'h00);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'd1, 32'h0000_0022, 8'h02);
        @(posedge clk); #1;
        check("ovr acked write no ovf", {24'd0, ovf}, 32'h1);
        check("ovr acked write y1", y1, 32'h0000_0022);
        drive(1'b1, 1'b0, 3'd0, 32'h0, 8'h00);
        @(posedge clk); #1;
        check("ovr ovf cleared", {24'd0, ovf}, 32'h0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/demux8_buf.md
# demux8_buf

Registered 1-to-8 demultiplexer for the MIPS datapath: the write-side counterpart of `mux8`. It accepts one 32-bit word per handshake, tagged with a 3-bit destination select. It steers the word into one of eight output holding slots, and each slot keeps the word until its own consumer acknowledges it. This lets a single producer feed eight independent downstream consumers without losing data.

## Interface
- `WIDTH`, default 32, data width of input and every slot.
- `clk  in  1`  single clock; all state updates on rising edge.
- `rst  in  1`  synchronous, active-high reset.
- `in_valid  in  1`  producer offers `d`/`s` this cycle.
- `in_ready  out  1`  block accepts the offer this cycle.
- `d  in  WIDTH`  input word.
- `s  in  3`  destination slot index, 0..7.
- `y0`..`y7  out  WIDTH each`  slot data registers.
- `y_valid  out  8`  bit i set means slot i holds an unconsumed word.
- `y_ack  in  8`  bit i pulses to consume slot i. Ignored when `y_valid[i]=0`.
- `ovf  out  8`  sticky overwrite flags. Present only with `DEMUX8_OVERWRITE_EN`.

## Operation
- Each slot i has a 2-state FSM:
  - EMPTY (`y_valid[i]=0`) → FULL on a write to i.
  - FULL → EMPTY on `y_ack[i]` with no write to i in the same cycle.
  - FULL → FULL on a write to i (refill or overwrite).
- A write occurs when `in_valid & in_ready`. On a write, `y[s] <= d` and `y_valid[s] <= 1`. All other slots hold.
- Default `in_ready` (combinational) = `~y_valid[s] | y_ack[s]`. A full slot being acked in the same cycle accepts a new word: data is replaced and valid stays 1.
- `in_ready` depends only on `s`, `y_valid`, `y_ack`, never on `in_valid`.
- `y_ack[i]` on an EMPTY slot has no effect.
- Acks to several slots in one cycle are all honoured independently.
- Slot data registers change only on a write to that slot. An ack clears valid only; the data remains visible.
- `s` is always in range (3 bits), so there is no illegal index.

## Timing
- Reset values: `y0`..`y7` = 0, `y_valid` = 8'h00, `ovf` = 8'h00.
- While `rst` is high, `in_ready` = 0 and no write or ack takes effect. Reset asserted mid-stream discards all held words at that edge.
- Latency: a word written at edge N appears on `y[s]`, with `y_valid[s]=1`, immediately after edge N (one cycle).
- Ack at edge N: `y_valid[i]` is 0 after edge N.
- Throughput: one word per cycle, provided the target slot is empty or is being acked in that cycle.
- Back-to-back writes to the same slot with no ack: the second write stalls (`in_ready=0`) until an ack arrives.

## Configuration
- `DEMUX8_OVERWRITE_EN` undefined (default): behaviour as above; `ovf` port is absent.
- `DEMUX8_OVERWRITE_EN` defined:
  - `in_ready` = `~rst` constantly.
  - A write to a FULL slot without a same-cycle ack replaces the data and sets `ovf[s] <= 1`.
  - `ovf` bits clear only on reset.
  - A write to a FULL slot with a same-cycle ack does not set `ovf`.

## Test plan
- Reset: hold `rst=1` 2 cycles with `in_valid=1` → `y_valid=00`, all `yi=0`, `in_ready=0`. Release reset → `in_ready=1`.
- Fill all slots: write `d=32'h1000_000i` with `s=i` for i=0..7 on consecutive cycles → `y_valid=FF`, `yi=32'h1000_000i`, no stalls.
- Stall: slot 3 full, offer `s=3`, `d=32'hDEAD_BEEF`, no ack → `in_ready=0`, `y3` unchanged. Pulse `y_ack[3]` → `in_ready=1` that cycle, `y3=32'hDEAD_BEEF`, `y_valid[3]=1`.
- Simultaneous ack and write on different slots: write `s=5` while acking slot 2 → `y_valid[5]=1`, `y_valid[2]=0`, `y2` data retained.
- Reset mid-operation: `y_valid=FF`, then assert `rst` for 1 cycle → `y_valid=00`, all data 0.
- With `DEMUX8_OVERWRITE_EN`: slot 0 full, write `s=0`, `d=32'hCAFE_0001` with no ack → `in_ready=1`, `y0=32'hCAFE_0001`, `ovf=8'h01`. `ovf` stays 01 until reset.
